// File: rtl/uart_tx_fifo_if.sv
// Producer and UART-side signals of the transmit FIFO.
// The master drives writes and the UART busy status; the slave is the FIFO.
interface uart_tx_fifo_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_overflow;
    logic              is_transmitting;
    logic              transmit;
    logic [7:0]        tx_byte;

    modport master (
        output wr_en, wr_data, clr_overflow, is_transmitting,
        input  full, empty, count, overflow, transmit, tx_byte
    );

    modport slave (
        input  wr_en, wr_data, clr_overflow, is_transmitting,
        output full, empty, count, overflow, transmit, tx_byte
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter: circular buffer plus a drain FSM
// that pops one byte per transmitter busy period and strobes transmit.
module uart_tx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input logic           CLK,
    input logic           rst_n,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StSent, StBusy} state_e;

    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              transmit_q, transmit_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    state_e            state_q, state_d;
    logic              wr_accept;
    logic              pop;

    assign wr_accept = bus.wr_en & ~full_q;

    // Drain FSM: a pop only happens from idle, and the FSM must see the
    // transmitter go busy and then idle again before it may pop the next byte.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty_q && !bus.is_transmitting) begin
                    pop     = 1'b1;
                    state_d = StSent;
                end
            end
            StSent: begin
                if (bus.is_transmitting) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!bus.is_transmitting) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        transmit_d = pop;
        tx_byte_d  = tx_byte_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            tx_byte_d = mem_q[rd_ptr_q];
        end

        unique case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A dropped write takes priority over a clear in the same cycle.
        if (bus.wr_en && full_q) begin
            overflow_d = 1'b1;
        end else if (bus.clr_overflow) begin
            overflow_d = 1'b0;
        end

        full_d  = (count_d == FullCount);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.transmit = transmit_q;
    assign bus.tx_byte  = tx_byte_q;

    a_transmit_single_cycle: assert property (
        @(posedge CLK) disable iff (!rst_n) transmit_q |=> !transmit_q
    );
    a_full_empty_exclusive: assert property (
        @(posedge CLK) disable iff (!rst_n) !(full_q && empty_q)
    );
endmodule
